zap_regf_banked: RTL and testbench



---
 rtl/zap_regf_banked_pkg.sv | 64 ++++++
 rtl/zap_regf_flush_fsm.sv | 53 +++++
 rtl/zap_regf_banked.sv | 208 ++++++++++++++++++++
 tb/tb_zap_regf_banked.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_regf_banked_pkg.sv
// Shared constants for the banked ZAP register file: physical slot map, processor modes, CPSR bits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zap_regf_banked_pkg;

    // Physical slot map. Slots 0..14 are the user-mode R0..R14; FIQ R8..R13
    // occupy 18..23 and are reached through ordinary writes by index.
    localparam int ARCH_PC       = 15;
    localparam int PHY_PC        = 15;
    localparam int PHY_CPSR      = 17;
    localparam int PHY_FIQ_R14   = 24;
    localparam int PHY_IRQ_R14   = 26;
    localparam int PHY_SVC_R14   = 28;
    localparam int PHY_UND_R14   = 30;
    localparam int PHY_ABT_R14   = 32;
    localparam int PHY_FIQ_SPSR  = 33;
    localparam int PHY_IRQ_SPSR  = 34;
    localparam int PHY_SVC_SPSR  = 35;
    localparam int PHY_UND_SPSR  = 36;
    localparam int PHY_ABT_SPSR  = 37;

    typedef enum logic [4:0] {
        MODE_USR = 5'h10,
        MODE_FIQ = 5'h11,
        MODE_IRQ = 5'h12,
        MODE_SVC = 5'h13,
        MODE_ABT = 5'h17,
        MODE_UND = 5'h1B
    } mode_t;

    localparam int CPSR_T = 5;
    localparam int CPSR_F = 6;
    localparam int CPSR_I = 7;

    localparam logic [31:0] CPSR_RESET = 32'h0000_00D3;

    typedef enum logic {
        FSM_IDLE  = 1'b0,
        FSM_FLUSH = 1'b1
    } flush_state_t;

    // Banked link register of an exception target mode.
    function automatic int lr_index(input mode_t m);
        case (m)
            MODE_FIQ: return PHY_FIQ_R14;
            MODE_IRQ: return PHY_IRQ_R14;
            MODE_ABT: return PHY_ABT_R14;
            MODE_UND: return PHY_UND_R14;
            default:  return PHY_SVC_R14;
        endcase
    endfunction

    // Banked saved-PSR of an exception target mode.
    function automatic int spsr_index(input mode_t m);
        case (m)
            MODE_FIQ: return PHY_FIQ_SPSR;
            MODE_IRQ: return PHY_IRQ_SPSR;
            MODE_ABT: return PHY_ABT_SPSR;
            MODE_UND: return PHY_UND_SPSR;
            default:  return PHY_SVC_SPSR;
        endcase
    endfunction

endpackage

// File: rtl/zap_regf_flush_fsm.sv
// Counted flush sequencer: holds clear for FLUSH_CYCLES cycles after a trigger.
// Latency: clear rises the cycle after i_trigger.
// Backpressure: none; triggers arriving while flushing are ignored.
// Ports: i_clk/i_reset, i_trigger (one-cycle request), o_clear (flush request), o_in_flush (gate).
module zap_regf_flush_fsm
    import zap_regf_banked_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
)(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_trigger,
    output logic o_clear,
    output logic o_in_flush
);

    flush_state_t state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= FSM_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            FSM_IDLE: begin
                if (i_trigger) begin
                    state_d = FSM_FLUSH;
                    cnt_d   = 4'(FLUSH_CYCLES - 1);
                end
            end
            FSM_FLUSH: begin
                if (cnt_q == 4'd0) state_d = FSM_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = FSM_IDLE;
        endcase
    end

    always_comb begin
        o_clear    = (state_q == FSM_FLUSH);
        o_in_flush = (state_q == FSM_FLUSH);
    end

endmodule

// File: rtl/zap_regf_banked.sv
// Banked ZAP register file with PC/CPSR path, exception entry and counted pipeline flush.
// Latency: reads combinational (with same-cycle write bypass); all state updates on the i_clk edge.
// Backpressure: during a flush all writeback and exception inputs are dropped; interrupts stay pending at source.
// Ports: read indices/data (packed), two write ports, flag update, exception requests and vectors,
// PC stall/redirect controls; outputs PC, CPSR, flush request and fiq/irq acks.
module zap_regf_banked
    import zap_regf_banked_pkg::*;
#(
    parameter int          PHY_REGS     = 46,
    parameter int          NUM_RD       = 4,
    parameter int          BYPASS       = 1,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'd0,
    localparam int         IDX_W        = $clog2(PHY_REGS)
)(
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    input  logic                    i_data_stall,
    input  logic                    i_clear_from_alu,
    input  logic                    i_stall_from_decode,
    input  logic                    i_stall_from_issue,
    input  logic                    i_stall_from_shifter,
    input  logic [31:0]             i_pc_from_alu,
    input  logic [31:0]             i_data_abort_vector,
    input  logic [31:0]             i_fiq_vector,
    input  logic [31:0]             i_irq_vector,
    input  logic [31:0]             i_instruction_abort_vector,
    input  logic [31:0]             i_swi_vector,
    input  logic [31:0]             i_und_vector,
    input  logic [NUM_RD*IDX_W-1:0] i_rd_index,
    input  logic                    i_wr_en,
    input  logic                    i_wr_en_1,
    input  logic [IDX_W-1:0]        i_wr_index,
    input  logic [IDX_W-1:0]        i_wr_index_1,
    input  logic [31:0]             i_wr_data,
    input  logic [31:0]             i_wr_data_1,
    input  logic                    i_flag_upd,
    input  logic [3:0]              i_flags,
    input  logic                    i_irq,
    input  logic                    i_fiq,
    input  logic                    i_instr_abt,
    input  logic                    i_data_abt,
    input  logic                    i_swi,
    input  logic                    i_und,
    input  logic [31:0]             i_pc_buf_ff,
    output logic [NUM_RD*32-1:0]    o_rd_data,
    output logic [31:0]             o_pc,
    output logic [31:0]             o_cpsr,
    output logic                    o_clear_from_writeback,
    output logic                    o_fiq_ack,
    output logic                    o_irq_ack
);

    localparam logic [IDX_W-1:0] IDX_PC   = IDX_W'(ARCH_PC);
    localparam logic [IDX_W-1:0] IDX_CPSR = IDX_W'(PHY_CPSR);

    logic [31:0] regs [PHY_REGS];
    logic [31:0] pc_q, pc_d, cpsr_q, cpsr_d;
    logic        in_flush, idle;

    // Exception selection.
    logic        exc_take, exc_fiq, exc_irq;
    mode_t       exc_mode;
    logic [31:0] exc_vec, exc_ret;
    logic [IDX_W-1:0] exc_lr_idx, exc_spsr_idx;

    assign idle = ~in_flush;

    always_comb begin
        exc_take = 1'b0;
        exc_fiq  = 1'b0;
        exc_irq  = 1'b0;
        exc_mode = MODE_SVC;
        exc_vec  = '0;
        exc_ret  = i_pc_buf_ff - 32'd4;
        if (idle) begin
            if (i_data_abt) begin
                exc_take = 1'b1; exc_mode = MODE_ABT; exc_vec = i_data_abort_vector;
                exc_ret  = i_pc_buf_ff;
            end else if (i_fiq && !cpsr_q[CPSR_F]) begin
                exc_take = 1'b1; exc_mode = MODE_FIQ; exc_vec = i_fiq_vector; exc_fiq = 1'b1;
            end else if (i_irq && !cpsr_q[CPSR_I]) begin
                exc_take = 1'b1; exc_mode = MODE_IRQ; exc_vec = i_irq_vector; exc_irq = 1'b1;
            end else if (i_instr_abt) begin
                exc_take = 1'b1; exc_mode = MODE_ABT; exc_vec = i_instruction_abort_vector;
            end else if (i_swi) begin
                exc_take = 1'b1; exc_mode = MODE_SVC; exc_vec = i_swi_vector;
            end else if (i_und) begin
                exc_take = 1'b1; exc_mode = MODE_UND; exc_vec = i_und_vector;
            end
        end
    end

    assign exc_lr_idx   = IDX_W'(lr_index(exc_mode));
    assign exc_spsr_idx = IDX_W'(spsr_index(exc_mode));

    // Writeback acceptance: exceptions outrank ordinary writes.
    logic wb_ok, wr0_ok, wr1_ok, wr0_arr, wr1_arr;
    logic pc_hit, cpsr_hit, cpsr_chg, trigger;
    logic [31:0] pc_dat, cpsr_dat, cpsr_wr_val;

    assign wb_ok   = idle & i_valid & ~exc_take;
    assign wr0_ok  = wb_ok & i_wr_en   & (int'(i_wr_index)   < PHY_REGS);
    assign wr1_ok  = wb_ok & i_wr_en_1 & (int'(i_wr_index_1) < PHY_REGS);
    assign wr0_arr = wr0_ok & (i_wr_index   != IDX_PC) & (i_wr_index   != IDX_CPSR);
    assign wr1_arr = wr1_ok & (i_wr_index_1 != IDX_PC) & (i_wr_index_1 != IDX_CPSR);

    assign pc_hit   = (wr0_ok && i_wr_index == IDX_PC)   || (wr1_ok && i_wr_index_1 == IDX_PC);
    assign pc_dat   = (wr1_ok && i_wr_index_1 == IDX_PC)   ? i_wr_data_1 : i_wr_data;
    assign cpsr_hit = (wr0_ok && i_wr_index == IDX_CPSR) || (wr1_ok && i_wr_index_1 == IDX_CPSR);
    assign cpsr_dat = (wr1_ok && i_wr_index_1 == IDX_CPSR) ? i_wr_data_1 : i_wr_data;

    // User mode cannot alter the control byte; only a real change of it needs a flush.
    assign cpsr_wr_val = (cpsr_q[4:0] == MODE_USR) ? {cpsr_dat[31:8], cpsr_q[7:0]} : cpsr_dat;
    assign cpsr_chg    = cpsr_hit && (cpsr_wr_val[7:0] != cpsr_q[7:0]);
    assign trigger     = exc_take | (wb_ok & pc_hit) | cpsr_chg;

    always_comb begin
        cpsr_d = cpsr_q;
        if (exc_take) begin
            cpsr_d[4:0]   = exc_mode;
            cpsr_d[CPSR_I] = 1'b1;
            cpsr_d[CPSR_T] = 1'b0;
            if (exc_fiq) cpsr_d[CPSR_F] = 1'b1;
        end else if (wb_ok) begin
            if (cpsr_hit)   cpsr_d = cpsr_wr_val;
            if (pc_hit)     cpsr_d[CPSR_T] = pc_dat[0];
            if (i_flag_upd) cpsr_d[31:28] = i_flags;
        end
    end

    always_comb begin
        if (exc_take)                                  pc_d = exc_vec;
        else if (wb_ok && pc_hit)                      pc_d = pc_dat & ~32'd1;
        else if (in_flush || i_data_stall)             pc_d = pc_q;
        else if (i_clear_from_alu)                     pc_d = i_pc_from_alu;
        else if (i_stall_from_decode || i_stall_from_issue || i_stall_from_shifter)
                                                       pc_d = pc_q;
        else                                           pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int r = 0; r < PHY_REGS; r++) regs[r] <= '0;
        end else begin
            if (exc_take) begin
                regs[exc_lr_idx]   <= exc_ret;
                regs[exc_spsr_idx] <= cpsr_q;
            end
            if (wr0_arr) regs[i_wr_index]   <= i_wr_data;
            if (wr1_arr) regs[i_wr_index_1] <= i_wr_data_1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q      <= RESET_PC;
            cpsr_q    <= CPSR_RESET;
            o_fiq_ack <= 1'b0;
            o_irq_ack <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            cpsr_q    <= cpsr_d;
            o_fiq_ack <= exc_fiq;
            o_irq_ack <= exc_irq;
        end
    end

    zap_regf_flush_fsm #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_flush (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_trigger  (trigger),
        .o_clear    (o_clear_from_writeback),
        .o_in_flush (in_flush)
    );

    assign o_pc   = pc_q;
    assign o_cpsr = cpsr_q;

    // Read ports: PC and CPSR live in dedicated flops, everything else in the array.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [IDX_W-1:0] idx;
        logic [31:0]      flop_val, val;

        assign idx = i_rd_index[k*IDX_W +: IDX_W];

        always_comb begin
            if (idx == IDX_PC)               flop_val = pc_q;
            else if (idx == IDX_CPSR)        flop_val = cpsr_q;
            else if (int'(idx) < PHY_REGS)   flop_val = regs[idx];
            else                             flop_val = '0;
        end

        if (BYPASS != 0) begin : g_byp
            always_comb begin
                val = flop_val;
                if (wr0_ok && i_wr_index   == idx) val = i_wr_data;
                if (wr1_ok && i_wr_index_1 == idx) val = i_wr_data_1;
            end
        end else begin : g_nobyp
            assign val = flop_val;
        end

        assign o_rd_data[k*32 +: 32] = val;
    end

endmodule

// File: tb/tb_zap_regf_banked.sv
// Randomised and directed bench for zap_regf_banked against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_zap_regf_banked;

    localparam int PHY_REGS = 46;
    localparam int NUM_RD   = 4;
    localparam int IDX_W    = 6;
    localparam int FLUSH_CYCLES = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid, data_stall, clear_alu, st_dec, st_iss, st_shf;
    logic [31:0] pc_alu, v_dabt, v_fiq, v_irq, v_iabt, v_swi, v_und;
    logic [NUM_RD*IDX_W-1:0] rd_index;
    logic        we0, we1;
    logic [IDX_W-1:0] wi0, wi1;
    logic [31:0] wd0, wd1;
    logic        flag_upd;
    logic [3:0]  flags;
    logic        irq, fiq, iabt, dabt, swi, und;
    logic [31:0] pc_buf;
    logic [NUM_RD*32-1:0] rd_data;
    logic [31:0] pc, cpsr;
    logic        clear, fiq_ack, irq_ack;

    zap_regf_banked #(.PHY_REGS(PHY_REGS), .NUM_RD(NUM_RD), .BYPASS(1),
                      .FLUSH_CYCLES(FLUSH_CYCLES), .RESET_PC(32'd0)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_data_stall(data_stall),
        .i_clear_from_alu(clear_alu), .i_stall_from_decode(st_dec),
        .i_stall_from_issue(st_iss), .i_stall_from_shifter(st_shf),
        .i_pc_from_alu(pc_alu), .i_data_abort_vector(v_dabt), .i_fiq_vector(v_fiq),
        .i_irq_vector(v_irq), .i_instruction_abort_vector(v_iabt),
        .i_swi_vector(v_swi), .i_und_vector(v_und), .i_rd_index(rd_index),
        .i_wr_en(we0), .i_wr_en_1(we1), .i_wr_index(wi0), .i_wr_index_1(wi1),
        .i_wr_data(wd0), .i_wr_data_1(wd1), .i_flag_upd(flag_upd), .i_flags(flags),
        .i_irq(irq), .i_fiq(fiq), .i_instr_abt(iabt), .i_data_abt(dabt),
        .i_swi(swi), .i_und(und), .i_pc_buf_ff(pc_buf), .o_rd_data(rd_data),
        .o_pc(pc), .o_cpsr(cpsr), .o_clear_from_writeback(clear),
        .o_fiq_ack(fiq_ack), .o_irq_ack(irq_ack)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [PHY_REGS];
    logic [31:0] m_pc, m_cpsr;
    int          m_flush_left;
    logic        m_fiq_ack, m_irq_ack;

    function automatic int bank_lr(input int mode);
        case (mode)
            'h11: return 24; 'h12: return 26; 'h17: return 32; 'h1B: return 30;
            default: return 28;
        endcase
    endfunction

    function automatic int bank_spsr(input int mode);
        case (mode)
            'h11: return 33; 'h12: return 34; 'h17: return 37; 'h1B: return 36;
            default: return 35;
        endcase
    endfunction

    // 0 none, 1 dabt, 2 fiq, 3 irq, 4 iabt, 5 swi, 6 und
    function automatic int pick_exc();
        if (m_flush_left > 0) return 0;
        if (dabt) return 1;
        if (fiq && !m_cpsr[6]) return 2;
        if (irq && !m_cpsr[7]) return 3;
        if (iabt) return 4;
        if (swi) return 5;
        if (und) return 6;
        return 0;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < PHY_REGS; r++) m_regs[r] = 32'd0;
        m_pc = 32'd0; m_cpsr = 32'hD3; m_flush_left = 0;
        m_fiq_ack = 1'b0; m_irq_ack = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        logic [31:0] v;
        if (idx == 15)            v = m_pc;
        else if (idx == 17)       v = m_cpsr;
        else if (idx < PHY_REGS)  v = m_regs[idx];
        else                      v = 32'd0;
        if (m_flush_left == 0 && valid && pick_exc() == 0) begin
            if (we0 && int'(wi0) == idx && idx < PHY_REGS) v = wd0;
            if (we1 && int'(wi1) == idx && idx < PHY_REGS) v = wd1;
        end
        return v;
    endfunction

    function automatic void model_step();
        int          e, mode, idx;
        logic [31:0] nxt_pc, ret, vec, data, newc;
        logic        trig, pcw, cw, tbit;
        m_fiq_ack = 1'b0; m_irq_ack = 1'b0;
        if (m_flush_left > 0) begin
            m_flush_left--;
            return;
        end
        trig = 1'b0; pcw = 1'b0; cw = 1'b0; tbit = 1'b0; newc = m_cpsr;
        if (data_stall)                    nxt_pc = m_pc;
        else if (clear_alu)                nxt_pc = pc_alu;
        else if (st_dec || st_iss || st_shf) nxt_pc = m_pc;
        else                               nxt_pc = m_pc + 32'd4;
        e = pick_exc();
        if (e != 0) begin
            ret = pc_buf - 32'd4;
            case (e)
                1: begin mode = 'h17; vec = v_dabt; ret = pc_buf; end
                2: begin mode = 'h11; vec = v_fiq; m_fiq_ack = 1'b1; end
                3: begin mode = 'h12; vec = v_irq; m_irq_ack = 1'b1; end
                4: begin mode = 'h17; vec = v_iabt; end
                5: begin mode = 'h13; vec = v_swi; end
                default: begin mode = 'h1B; vec = v_und; end
            endcase
            m_regs[bank_lr(mode)]   = ret;
            m_regs[bank_spsr(mode)] = m_cpsr;
            m_cpsr[4:0] = 5'(mode);
            m_cpsr[7] = 1'b1;
            m_cpsr[5] = 1'b0;
            if (e == 2) m_cpsr[6] = 1'b1;
            nxt_pc = vec;
            trig = 1'b1;
        end else if (valid) begin
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? we0 : we1) begin
                    idx  = int'((p == 0) ? wi0 : wi1);
                    data = (p == 0) ? wd0 : wd1;
                    if (idx == 15) begin
                        nxt_pc = {data[31:1], 1'b0}; tbit = data[0]; pcw = 1'b1;
                    end else if (idx == 17) begin
                        newc = (m_cpsr[4:0] == 5'h10) ? {data[31:8], m_cpsr[7:0]} : data;
                        cw = 1'b1;
                    end else if (idx < PHY_REGS) begin
                        m_regs[idx] = data;
                    end
                end
            end
            if (cw) begin
                if (newc[7:0] != m_cpsr[7:0]) trig = 1'b1;
                m_cpsr = newc;
            end
            if (pcw) begin
                m_cpsr[5] = tbit;
                trig = 1'b1;
            end
            if (flag_upd) m_cpsr[31:28] = flags;
        end
        m_pc = nxt_pc;
        if (trig) m_flush_left = FLUSH_CYCLES;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        rst = 0; valid = 0; data_stall = 0; clear_alu = 0; st_dec = 0; st_iss = 0; st_shf = 0;
        pc_alu = 0; v_dabt = 32'h10; v_fiq = 32'h1C; v_irq = 32'h18; v_iabt = 32'h0C;
        v_swi = 32'h08; v_und = 32'h04;
        we0 = 0; we1 = 0; wi0 = 0; wi1 = 0; wd0 = 0; wd1 = 0; flag_upd = 0; flags = 0;
        irq = 0; fiq = 0; iabt = 0; dabt = 0; swi = 0; und = 0; pc_buf = 0;
    endtask

    task automatic set_rd(input int k, input int idx);
        rd_index[k*IDX_W +: IDX_W] = IDX_W'(idx);
    endtask

    // Inputs are already applied; check reads, clock once, then check state.
    task automatic run_cycle();
        #2;
        for (int k = 0; k < NUM_RD; k++)
            check($sformatf("rd%0d", k), rd_data[k*32 +: 32],
                  model_read(int'(rd_index[k*IDX_W +: IDX_W])));
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        check("pc", pc, m_pc);
        check("cpsr", cpsr, m_cpsr);
        check("clear", {31'd0, clear}, {31'd0, m_flush_left > 0});
        check("fiq_ack", {31'd0, fiq_ack}, {31'd0, m_fiq_ack});
        check("irq_ack", {31'd0, irq_ack}, {31'd0, m_irq_ack});
    endtask

    task automatic wr_port0(input int idx, input logic [31:0] d);
        valid = 1; we0 = 1; wi0 = IDX_W'(idx); wd0 = d;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin idle_inputs(); run_cycle(); end
    endtask

    logic [4:0] mlist [6] = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B};

    task automatic random_inputs();
        logic [31:0] d;
        idle_inputs();
        valid = ($urandom_range(0, 9) < 7);
        data_stall = ($urandom_range(0, 9) == 0);
        clear_alu  = ($urandom_range(0, 9) == 0);
        st_dec = ($urandom_range(0, 19) == 0);
        st_iss = ($urandom_range(0, 19) == 0);
        st_shf = ($urandom_range(0, 19) == 0);
        pc_alu = $urandom(); pc_buf = $urandom();
        v_dabt = $urandom(); v_fiq = $urandom(); v_irq = $urandom();
        v_iabt = $urandom(); v_swi = $urandom(); v_und = $urandom();
        for (int p = 0; p < 2; p++) begin
            int sel;
            sel = $urandom_range(0, 19);
            d = $urandom();
            if (sel == 0) wd0 = 0;
            if (sel < 2) begin
                d[7:5] = 3'($urandom_range(0, 7));
                d[4:0] = mlist[$urandom_range(0, 5)];
            end
            if (p == 0) begin
                we0 = $urandom_range(0, 1);
                wi0 = (sel < 2) ? 6'd17 : (sel < 4) ? 6'd15 : 6'($urandom_range(0, 63));
                wd0 = d;
            end else begin
                we1 = $urandom_range(0, 1);
                wi1 = (sel < 2) ? 6'd17 : (sel < 4) ? 6'd15 : 6'($urandom_range(0, 63));
                wd1 = d;
            end
        end
        flag_upd = ($urandom_range(0, 4) == 0);
        flags = 4'($urandom_range(0, 15));
        irq  = ($urandom_range(0, 19) == 0);
        fiq  = ($urandom_range(0, 29) == 0);
        dabt = ($urandom_range(0, 39) == 0);
        iabt = ($urandom_range(0, 39) == 0);
        swi  = ($urandom_range(0, 39) == 0);
        und  = ($urandom_range(0, 39) == 0);
        for (int k = 0; k < NUM_RD; k++) begin
            if ($urandom_range(0, 3) == 0 && we0) set_rd(k, int'(wi0));
            else set_rd(k, $urandom_range(0, 63));
        end
    endtask

    initial begin
        idle_inputs();
        rd_index = '0;
        model_reset();
        set_rd(0, 3); set_rd(1, 26); set_rd(2, 34); set_rd(3, 32);

        // Reset then three free-running cycles.
        rst = 1; @(posedge clk); #1; rst = 1; run_cycle();
        check("reset_pc", pc, 32'd0);
        check("reset_cpsr", cpsr, 32'hD3);
        idle_cycles(3);
        check("free_run_pc", pc, 32'd12);

        // Unmask IRQ (control byte changes -> flush), then take an IRQ.
        idle_inputs(); wr_port0(17, 32'h53); run_cycle();
        idle_cycles(FLUSH_CYCLES);
        idle_inputs(); irq = 1; pc_buf = 32'h108; v_irq = 32'h18; run_cycle();
        check("irq_pc", pc, 32'h18);
        check("irq_cpsr", cpsr, 32'hD2);
        check("irq_ack", {31'd0, irq_ack}, 32'd1);
        check("irq_r14", rd_data[1*32 +: 32], 32'h104);
        check("irq_spsr", rd_data[2*32 +: 32], 32'h53);
        idle_cycles(FLUSH_CYCLES);

        // FIQ and data abort together: abort wins, FIQ waits out the flush.
        idle_inputs(); wr_port0(17, 32'h13); run_cycle();
        idle_cycles(FLUSH_CYCLES);
        idle_inputs(); fiq = 1; dabt = 1; pc_buf = 32'h200; run_cycle();
        check("dabt_pc", pc, 32'h10);
        check("dabt_no_fiq_ack", {31'd0, fiq_ack}, 32'd0);
        check("abt_r14", rd_data[3*32 +: 32], 32'h200);
        for (int i = 0; i < FLUSH_CYCLES + 1; i++) begin
            idle_inputs(); fiq = 1; pc_buf = 32'h300; run_cycle();
        end
        check("fiq_pc", pc, 32'h1C);
        check("fiq_cpsr", cpsr, 32'hD1);
        check("fiq_ack", {31'd0, fiq_ack}, 32'd1);
        idle_cycles(FLUSH_CYCLES);

        // Masked IRQ is ignored.
        idle_inputs(); irq = 1; run_cycle();
        check("masked_irq_pc", pc, 32'h20);

        // PC write with Thumb bit; writes during flush are dropped.
        idle_inputs(); wr_port0(15, 32'h2001); run_cycle();
        check("pcw_pc", pc, 32'h2000);
        check("pcw_t", {31'd0, cpsr[5]}, 32'd1);
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            idle_inputs(); wr_port0(5, 32'h55); set_rd(0, 5); run_cycle();
        end
        check("flush_done", {31'd0, clear}, 32'd0);

        // Both ports write R3: port 1 wins on bypass and in the flop.
        idle_inputs(); wr_port0(3, 32'hAA); we1 = 1; wi1 = 6'd3; wd1 = 32'hBB; set_rd(0, 3);
        #2; check("byp_r3", rd_data[31:0], 32'hBB);
        run_cycle();
        idle_inputs(); #2; check("flop_r3", rd_data[31:0], 32'hBB);
        run_cycle();

        // Drop to USR, then a USR control-byte write is masked and does not flush.
        idle_inputs(); wr_port0(17, 32'h10); run_cycle();
        idle_cycles(FLUSH_CYCLES);
        idle_inputs(); wr_port0(17, 32'h1F); run_cycle();
        check("usr_cpsr", cpsr, 32'h10);
        check("usr_no_flush", {31'd0, clear}, 32'd0);

        // Reset in the middle of a flush.
        idle_inputs(); wr_port0(15, 32'h100); run_cycle();
        idle_inputs(); rst = 1; run_cycle();
        check("rst_mid_flush", {31'd0, clear}, 32'd0);
        idle_cycles(1);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            random_inputs();
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
